// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone command initiator.
// The optional abort timer is enabled with the WB_TIMEOUT_EN macro.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;

    localparam logic [WB_DAT_W/8-1:0] SEL_ALL = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Abort timer for a Wishbone cycle: expired_o pulses in the LIMIT-th consecutive enabled cycle.
// Instantiated only when WB_TIMEOUT_EN is defined.
module wb_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expiry coincides with the edge on which the count reaches LIMIT.
    assign expired_o = enable_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer initiator: valid/ready command in, valid/ready response out.
// Define WB_TIMEOUT_EN to abort a cycle after TIMEOUT_CYC cycles without ACK.
module wb_cmd_initiator
    import wb_pkg::*;
#(
    parameter int ADR_W       = WB_ADR_W,
    parameter int DAT_W       = WB_DAT_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [ADR_W-1:0]   cmd_adr_i,
    input  logic [DAT_W-1:0]   cmd_dat_i,
    input  logic [DAT_W/8-1:0] cmd_sel_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DAT_W-1:0]   rsp_dat_o,
    output logic               rsp_err_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    input  logic [DAT_W-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i
);

    wb_state_e          state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [DAT_W/8-1:0] sel_q, sel_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               timeout_expired;

`ifdef WB_TIMEOUT_EN
    wb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk_i     (wb_clk_i),
        .rst_n_i   (wb_rst_n_i),
        .clear_i   (state_q != BUS),
        .enable_i  ((state_q == BUS) && !wbm_ack_i),
        .expired_o (timeout_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout_expired    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    sel_d       = cmd_sel_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = BUS;
                end
            end
            BUS: begin
                // ACK takes priority over a timeout expiring in the same cycle.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else if (timeout_expired) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator; the abort-timer scenarios run when WB_TIMEOUT_EN is defined.
module tb_wb_cmd_initiator;
    import wb_pkg::*;

`ifdef WB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;

    int n_tests = 0;
    int n_fail  = 0;

    wb_cmd_initiator #(
        .ADR_W       (32),
        .DAT_W       (32),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_dat_i   (rdat),
        .wbm_ack_i   (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; rdat = '0; ack = 1'b0;
        repeat (3) step();
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        n_tests++; if ({cyc, stb, we} !== 3'b000) begin n_fail++; $display("FAIL rst_cyc_stb_we: got %b expected 000", {cyc, stb, we}); end
        n_tests++; if ({sel, adr, wdat} !== 68'd0) begin n_fail++; $display("FAIL rst_wbm_fields: got sel=%h adr=%h dat=%h expected 0", sel, adr, wdat); end
        n_tests++; if ({rsp_valid, rsp_err, rsp_dat} !== 34'd0) begin n_fail++; $display("FAIL rst_rsp: got v=%b e=%b d=%h expected 0", rsp_valid, rsp_err, rsp_dat); end
        rst_n = 1'b1;
        step();
        n_tests++; if (cmd_ready !== 1'b1 || cyc !== 1'b0) begin n_fail++; $display("FAIL rst_release: got ready=%b cyc=%b expected 1 0", cmd_ready, cyc); end
        $display("[TB] reset checked");
    endtask

    task automatic test_write();
        int stb_cycles = 0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004; cmd_dat = 32'hDEAD_BEEF; cmd_sel = SEL_ALL;
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_idle: got %b expected 1", cmd_ready); end
        step();
        cmd_valid = 1'b0; cmd_dat = 32'h0; cmd_adr = 32'h0; cmd_sel = 4'h0; cmd_we = 1'b0;
        rdat = 32'h1234_5678;
        n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_bus: got %b expected 0", cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            if (stb === 1'b1) stb_cycles++;
            n_tests++;
            if ({cyc, stb, we} !== 3'b111 || adr !== 32'h3000_0004 || wdat !== 32'hDEAD_BEEF || sel !== 4'hF) begin
                n_fail++;
                $display("FAIL wr_bus_stable[%0d]: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h expected 1 1 1 30000004 deadbeef f",
                         i, cyc, stb, we, adr, wdat, sel);
            end
            if (i == 3) ack = 1'b1;
            step();
        end
        ack = 1'b0;
        n_tests++; if (stb_cycles != 4 || {cyc, stb} !== 2'b00) begin n_fail++; $display("FAIL wr_span: got %0d cycles end cyc=%b stb=%b expected 4 0 0", stb_cycles, cyc, stb); end
        n_tests++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp: got v=%b d=%h e=%b expected 1 00000000 0", rsp_valid, rsp_dat, rsp_err); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_done: got v=%b ready=%b expected 0 1", rsp_valid, cmd_ready); end
        $display("[TB] write adr=30000004 dat=deadbeef completed");
    endtask

    task automatic test_read_zero_wait();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_dat = 32'hFFFF_FFFF; cmd_sel = SEL_ALL;
        step();
        cmd_valid = 1'b0;
        n_tests++; if ({cyc, stb, we} !== 3'b110 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_bus: got cyc=%b stb=%b we=%b v=%b expected 1 1 0 0", cyc, stb, we, rsp_valid); end
        ack = 1'b1; rdat = 32'hA5A5_5A5A;
        step();
        ack = 1'b0; rdat = 32'h0;
        n_tests++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'hA5A5_5A5A || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got v=%b d=%h e=%b expected 1 a5a55a5a 0", rsp_valid, rsp_dat, rsp_err); end
        n_tests++; if ({cyc, stb} !== 2'b00) begin n_fail++; $display("FAIL rd_cyc_drop: got %b expected 00", {cyc, stb}); end
        $display("[TB] read adr=30000000 rsp=%h", rsp_dat);
    endtask

    // Entered with the read response still pending.
    task automatic test_backpressure();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0008; cmd_dat = 32'h1122_3344; cmd_sel = 4'h3;
        for (int i = 0; i < 5; i++) begin
            ack = (i % 2 == 0); rdat = 32'hFFFF_FFFF;
            step();
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'hA5A5_5A5A || cmd_ready !== 1'b0 || cyc !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h ready=%b cyc=%b expected 1 a5a55a5a 0 0", i, rsp_valid, rsp_dat, cmd_ready, cyc);
            end
        end
        ack = 1'b0; rdat = 32'h0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc !== 1'b0) begin n_fail++; $display("FAIL bp_gap: got v=%b ready=%b cyc=%b expected 0 1 0", rsp_valid, cmd_ready, cyc); end
        step();
        cmd_valid = 1'b0;
        n_tests++; if (cyc !== 1'b1 || we !== 1'b1 || adr !== 32'h3000_0008 || sel !== 4'h3 || wdat !== 32'h1122_3344) begin
            n_fail++; $display("FAIL bp_next_cmd: got cyc=%b we=%b adr=%h sel=%h dat=%h expected 1 1 30000008 3 11223344", cyc, we, adr, sel, wdat);
        end
        ack = 1'b1; rdat = 32'h5555_AAAA;
        step();
        ack = 1'b0; rdat = 32'h0;
        n_tests++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0) begin n_fail++; $display("FAIL bp_next_rsp: got v=%b d=%h expected 1 00000000", rsp_valid, rsp_dat); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("[TB] backpressure 5 cycles then write adr=30000008 completed");
    endtask

    task automatic test_spurious_ack_idle();
        ack = 1'b1; rdat = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (cyc !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_dat !== 32'h0 || adr !== 32'h3000_0008) begin
                n_fail++;
                $display("FAIL idle_ack[%0d]: got cyc=%b v=%b ready=%b d=%h adr=%h expected 0 0 1 00000000 30000008", i, cyc, rsp_valid, cmd_ready, rsp_dat, adr);
            end
        end
        ack = 1'b0; rdat = 32'h0;
        $display("[TB] spurious ack in idle ignored");
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        int cnt = 0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0010; cmd_sel = SEL_ALL;
        step();
        cmd_valid = 1'b0; rdat = 32'h7777_7777;
        while (stb === 1'b1 && cnt < 50) begin
            cnt++;
            step();
        end
        n_tests++; if (cnt != 8) begin n_fail++; $display("FAIL to_stb_span: got %0d cycles expected 8", cnt); end
        n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0) begin n_fail++; $display("FAIL to_rsp: got v=%b e=%b d=%h expected 1 1 00000000", rsp_valid, rsp_err, rsp_dat); end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (7) step();
        ack = 1'b1; rdat = 32'hC0DE_0008;
        step();
        ack = 1'b0; rdat = 32'h0;
        n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'hC0DE_0008) begin n_fail++; $display("FAIL to_ack_wins: got v=%b e=%b d=%h expected 1 0 c0de0008", rsp_valid, rsp_err, rsp_dat); end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        $display("[TB] timeout abort and ack-on-expiry checked");
    endtask
`else
    task automatic test_no_timeout();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0010; cmd_sel = SEL_ALL;
        step();
        cmd_valid = 1'b0;
        repeat (20) step();
        n_tests++; if (stb !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL nto_wait: got stb=%b v=%b expected 1 0", stb, rsp_valid); end
        ack = 1'b1; rdat = 32'h0BAD_F00D;
        step();
        ack = 1'b0; rdat = 32'h0;
        n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL nto_rsp: got v=%b e=%b d=%h expected 1 0 0badf00d", rsp_valid, rsp_err, rsp_dat); end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        $display("[TB] long wait read adr=30000010 rsp=0badf00d");
    endtask
`endif

    task automatic test_reset_mid_bus();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0020; cmd_dat = 32'h9999_0000; cmd_sel = SEL_ALL;
        step();
        cmd_valid = 1'b0;
        step();
        n_tests++; if ({cyc, stb} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got %b expected 11", {cyc, stb}); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({cyc, stb} !== 2'b00 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async_drop: got cyc/stb=%b ready=%b expected 00 1", {cyc, stb}, cmd_ready); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        rst_n = 1'b1;
        step();
        n_tests++; if (rsp_valid !== 1'b0 || cyc !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after: got v=%b cyc=%b ready=%b expected 0 0 1", rsp_valid, cyc, cmd_ready); end
        $display("[TB] reset during bus cycle discarded transfer");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_zero_wait();
        test_backpressure();
        test_spurious_ack_idle();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_bus();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
